sub_div_comp_4_bit_seq: RTL

SUB_DIV_COMP_4_BIT_SEQ -- requirements
Module: sub_div_comp_4_bit_seq

---
 rtl/sub_div_comp_4_bit_seq_pkg.sv | 15 +
 rtl/sub_div_comp_4_bit_seq_div_step.sv | 22 ++
 rtl/sub_div_comp_4_bit_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sub_div_comp_4_bit_seq_pkg.sv
// Shared types and constants for the sequential subtract/divide decomposer.
package sub_div_comp_4_bit_seq_pkg;

  localparam int unsigned DEF_W = 4;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_div_comp_4_bit_seq_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract divisor if it fits.
module div_step
  import sub_div_comp_4_bit_seq_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic [W:0]   rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] divisor_i,
  output logic [W:0]   rem_o,
  output logic         q_o
);

  logic [W+1:0] shifted;

  always_comb begin
    shifted = {rem_i, bit_i};
    q_o     = (shifted >= (W+2)'(divisor_i));
    rem_o   = q_o ? (shifted[W:0] - (W+1)'(divisor_i)) : shifted[W:0];
  end

endmodule

// File: rtl/sub_div_comp_4_bit_seq.sv
// Recovers operand a from an adder/multiplier result: a = result - b, or a = result / b
// using a 2*W-cycle restoring divider.
module sub_div_comp_4_bit_seq
  import sub_div_comp_4_bit_seq_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           op,
  input  logic [2*W-1:0] result_in,
  input  logic [W-1:0]   b_in,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   a_out,
  output logic [W-1:0]   rem_out,
  output logic           ovf,
  output logic           dbz
);

  localparam int unsigned RW    = 2 * W;
  localparam int unsigned CNT_W = $clog2(RW);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [RW-1:0]    dvd_q, dvd_d;
  logic [W-1:0]     dvs_q, dvs_d;
  logic [W:0]       prem_q, prem_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     rem_q, rem_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [W:0]       step_rem;
  logic             step_q;
  logic [RW:0]      diff;
  logic [RW-1:0]    quot_next;

  div_step #(.W(W)) u_div_step (
    .rem_i     (prem_q),
    .bit_i     (dvd_q[RW-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      a_q     <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      a_q     <= a_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    a_d     = a_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;

    diff      = {1'b0, result_in} - (RW+1)'(b_in);
    // The dividend register doubles as the quotient shift register.
    quot_next = {dvd_q[RW-2:0], step_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op;
          dvd_d  = result_in;
          dvs_d  = b_in;
          prem_d = '0;
          cnt_d  = '0;
          a_d    = '0;
          rem_d  = '0;
          ovf_d  = 1'b0;
          dbz_d  = 1'b0;
          if (op == OP_SUB) begin
            state_d = DONE;
            a_d     = diff[W-1:0];
            ovf_d   = diff[RW] | (|diff[RW-1:W]);
          end else if (b_in == '0) begin
            state_d = DONE;
            a_d     = '1;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        dvd_d  = quot_next;
        prem_d = step_rem;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(RW - 1)) begin
          state_d = DONE;
          a_d     = quot_next[W-1:0];
          rem_d   = (op_q == OP_DIV) ? step_rem[W-1:0] : '0;
          ovf_d   = |quot_next[RW-1:W];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign a_out   = a_q;
  assign rem_out = rem_q;
  assign ovf     = ovf_q;
  assign dbz     = dbz_q;

endmodule
